// File: rtl/alu_operand_loader_if.sv
// Bus between the key/switch front-end loader and the 16-bit ALU it feeds.
// The master modport is the loader; the slave side is the board plus the ALU.
interface alu_operand_loader_if #(
    parameter int WORD_SIZE = 16,
    parameter int OP_SIZE   = 4
);
    logic                 key_ok;
    logic [WORD_SIZE-1:0] sw_in;
    logic [WORD_SIZE-1:0] alu_out;
    logic                 alu_zero_flag;
    logic [WORD_SIZE-1:0] data_1;
    logic [WORD_SIZE-1:0] data_2;
    logic [OP_SIZE-1:0]   sel;
    logic [WORD_SIZE-1:0] result;
    logic                 result_zero;
    logic                 result_valid;
    logic                 err;
    logic [2:0]           state;

    modport master (
        input  key_ok, sw_in, alu_out, alu_zero_flag,
        output data_1, data_2, sel, result, result_zero, result_valid, err, state
    );

    modport slave (
        output key_ok, sw_in, alu_out, alu_zero_flag,
        input  data_1, data_2, sel, result, result_zero, result_valid, err, state
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Debounced key-driven entry of operand A, operand B and opcode for the ALU,
// followed by a timed wait and a latch of the ALU result for display.
module alu_operand_loader #(
    parameter int WORD_SIZE       = 16,
    parameter int OP_SIZE         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ALU_LAT         = 1
) (
    input  logic clk,
    input  logic rst,
    alu_operand_loader_if.master bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    logic            key_s1_q, key_s2_q;
    logic            db_level_q, db_prev_q, press_q;
    logic [DB_W-1:0] db_cnt_q;

    state_t               state_q;
    logic [WORD_SIZE-1:0] data_1_q, data_2_q, result_q;
    logic [OP_SIZE-1:0]   sel_q;
    logic                 result_zero_q, result_valid_q, err_q;
    logic [3:0]           wait_q;
    logic                 op_valid_d;

    // Key is active-low, so every key register idles at the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1_q   <= 1'b1;
            key_s2_q   <= 1'b1;
            db_level_q <= 1'b1;
            db_prev_q  <= 1'b1;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
        end else begin
            key_s1_q  <= bus.key_ok;
            key_s2_q  <= key_s1_q;
            db_prev_q <= db_level_q;
            press_q   <= db_prev_q & ~db_level_q;
            if (key_s2_q == db_level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                db_cnt_q   <= '0;
                db_level_q <= key_s2_q;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        op_valid_d = bus.sw_in[OP_SIZE-1:0] inside
                     {OP_SIZE'(5), OP_SIZE'(6), OP_SIZE'(7), OP_SIZE'(8), OP_SIZE'(9)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_A;
            data_1_q       <= '0;
            data_2_q       <= '0;
            sel_q          <= '0;
            result_q       <= '0;
            result_zero_q  <= 1'b0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            wait_q         <= '0;
        end else begin
            case (state_q)
                S_A, S_SHOW: begin
                    if (press_q) begin
                        data_1_q       <= bus.sw_in;
                        result_valid_q <= 1'b0;
                        err_q          <= 1'b0;
                        state_q        <= S_B;
                    end
                end
                S_B: begin
                    if (press_q) begin
                        data_2_q <= bus.sw_in;
                        state_q  <= S_OP;
                    end
                end
                S_OP: begin
                    if (press_q) begin
                        if (op_valid_d) begin
                            sel_q   <= bus.sw_in[OP_SIZE-1:0];
                            wait_q  <= 4'(ALU_LAT);
                            state_q <= S_EXEC;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                end
                // Presses arriving while the ALU settles are dropped.
                S_EXEC: begin
                    if (wait_q == 4'd0) begin
                        result_q       <= bus.alu_out;
                        result_zero_q  <= bus.alu_zero_flag;
                        result_valid_q <= 1'b1;
                        state_q        <= S_SHOW;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                S_ERR: begin
                    if (press_q) begin
                        err_q   <= 1'b0;
                        state_q <= S_A;
                    end
                end
                default: state_q <= S_A;
            endcase
        end
    end

    assign bus.data_1       = data_1_q;
    assign bus.data_2       = data_2_q;
    assign bus.sel          = sel_q;
    assign bus.result       = result_q;
    assign bus.result_zero  = result_zero_q;
    assign bus.result_valid = result_valid_q;
    assign bus.err          = err_q;
    assign bus.state        = state_q;
endmodule
